score_seq: RTL and testbench
============================

Name: score_seq

Overview:
Score sequencing controller for the snake game. It keeps the 2-digit BCD score and the high score, and queues point awards from the game logic, applying them one point per cycle. It also sequences the end-of-game blink of the score display. It sits between the game FSM (start/over/eat/bonus pulses) and the score glyph renderer, which consumes the tens/ones digits and the display enable.

Parameters:
BONUS_PTS, 5, points queued by one bonus pulse (1..15)
PEND_MAX, 15, saturation value of the pending-points queue (4-bit)
BLINK_HALF, 16, frame ticks per blink half-period
BLINK_CYCLES, 4, number of full on/off blink periods after game over

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-low reset
game_start  in  1  one-cycle pulse: new game begins
game_over  in  1  one-cycle pulse: game ended (win or lose)
eat  in  1  one-cycle pulse: award 1 point
bonus  in  1  one-cycle pulse: award BONUS_PTS points
frame_tick  in  1  one-cycle pulse per video frame (vsync)
tens  out  4  current score tens digit, BCD
ones  out  4  current score ones digit, BCD
hi_tens  out  4  high score tens digit, BCD
hi_ones  out  4  high score ones digit, BCD
busy  out  1  pending points not yet applied
display_en  out  1  score glyphs visible
new_high  out  1  last finished game set a new high score
phase  out  3  FSM state, for debug

Behaviour:
- Reset (rst==0 at a clk edge): FSM=IDLE, tens=ones=0, hi_tens=hi_ones=0, pending=0, busy=0, display_en=1, new_high=0, blink counters=0.
- FSM states and encoding: IDLE=0, PLAY=1, DRAIN=2, BLINK=3, DONE=4.
- IDLE: awards ignored. game_start -> PLAY.
- PLAY: on game_over -> DRAIN if pending!=0 or an award arrives in the same cycle; otherwise -> BLINK.
- DRAIN: applies pending points. When pending reaches 0 -> BLINK. New eat/bonus pulses are ignored.
- BLINK: display_en toggles every BLINK_HALF frame_ticks, starting low on entry. After 2*BLINK_CYCLES toggles, display_en=1 and FSM -> DONE.
- DONE: holds the score. game_start -> PLAY.
- game_start in any state (PLAY, DRAIN, BLINK, DONE):
  - clears score, pending, new_high and blink counters; display_en=1; FSM -> PLAY next cycle.
  - The high score is kept.
  - game_start has priority over game_over and awards in the same cycle.
- Award queue:
  - Each cycle in PLAY: pending_next = min(PEND_MAX, pending - dec + eat + (bonus ? BONUS_PTS : 0)).
  - dec=1 when pending!=0; that cycle the score increments by 1.
  - eat and bonus in the same cycle add 1+BONUS_PTS.
  - Latency: first point is visible on tens/ones 2 cycles after the pulse (queue, then apply).
- BCD increment: ones==9 -> ones=0, tens+1. Score saturates at 99; further points are still drained from the queue but discarded.
- busy = (pending!=0), registered.
- High score: on the DRAIN/PLAY -> BLINK transition, if score > hi (compared as 8-bit BCD), hi <= score and new_high <= 1. Equal score gives no update.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
HISCORE_EN
- Defined: the high-score registers, compare logic and new_high are implemented as described above.
- Undefined: no high-score storage; hi_tens=hi_ones=0 and new_high=0 constantly. All other behaviour is unchanged.

Test Plan:
- Reset, game_start, 3 eat pulses 1 cycle apart -> tens=0, ones=3; busy deasserts 2 cycles after the last pulse; phase=1.
- Score 08, eat+bonus in the same cycle -> pending=6, busy=1 for 6 cycles, final tens=1, ones=4.
- Score 97, two bonus pulses, then drain -> score saturates at tens=9, ones=9; pending reaches 0; busy=0.
- Score 12 with pending=4, game_over -> DRAIN for 4 cycles, score 16, then BLINK:
  - display_en low for 16 ticks, high for 16 ticks, ×4, then DONE with display_en=1.
  - hi=16, new_high=1.
- Second game ending at score 16 -> no hi update, new_high=0. Third game ending at 20 -> hi_tens=2, hi_ones=0.
- game_start mid-BLINK at frame 5 -> next cycle phase=1, display_en=1, score 00, hi retained. rst=0 mid-PLAY -> all outputs to reset values including hi.

Source files
------------

// File: rtl/score_seq.sv
// score_seq - score sequencing controller for the snake game.
//
// Keeps the 2-digit BCD score and, optionally, the high score. Point awards
// from the game FSM are queued and applied one point per cycle. At game end
// the remaining queue is drained, the high score is updated, and the score
// display blinks for a fixed number of periods.
//
// Optional feature macro: HISCORE_EN
//   defined   : high-score registers, compare logic and new_high are built.
//   undefined : hi_tens/hi_ones/new_high are tied to zero.
//
// Ports:
//   clk         system clock
//   rst         synchronous reset, active low
//   game_start  1-cycle pulse, new game (priority over everything else)
//   game_over   1-cycle pulse, game ended
//   eat         1-cycle pulse, award 1 point
//   bonus       1-cycle pulse, award BONUS_PTS points
//   frame_tick  1-cycle pulse per video frame
//   tens, ones  current score, BCD
//   hi_tens, hi_ones  high score, BCD
//   busy        queued points not yet applied
//   display_en  score glyphs visible
//   new_high    last finished game set a new high score
//   phase       FSM state (IDLE=0 PLAY=1 DRAIN=2 BLINK=3 DONE=4)
//
// Interface note: every input is a single-cycle event pulse sampled on the
// rising clk edge; there is no valid/ready handshake and no back-pressure.
// Every output comes straight from a register.
module score_seq #(
  parameter int BONUS_PTS    = 5,
  parameter int PEND_MAX     = 15,
  parameter int BLINK_HALF   = 16,
  parameter int BLINK_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_start,
  input  logic       game_over,
  input  logic       eat,
  input  logic       bonus,
  input  logic       frame_tick,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [3:0] hi_tens,
  output logic [3:0] hi_ones,
  output logic       busy,
  output logic       display_en,
  output logic       new_high,
  output logic [2:0] phase
);

  localparam int TICK_W = $clog2(BLINK_HALF + 1);
  localparam int TOG_W  = $clog2(2 * BLINK_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLAY  = 3'd1,
    DRAIN = 3'd2,
    BLINK = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state;
  logic [3:0]        pending;
  logic [TICK_W-1:0] tick_cnt;
  logic [TOG_W-1:0]  toggle_cnt;

  // Next queue value in PLAY: one point leaves, new awards arrive, saturate.
  logic       dec;
  logic [5:0] q_sum;
  logic [3:0] pend_play;
  logic       award;
  // Saturating BCD increment of the score.
  logic [3:0] inc_tens;
  logic [3:0] inc_ones;
  // The cycle in which the game finishes and the blink sequence starts.
  logic       to_blink;

  always_comb begin
    dec       = (pending != 4'd0);
    award     = eat | bonus;
    q_sum     = 6'(pending) - 6'(dec) + 6'(eat) + (bonus ? 6'(BONUS_PTS) : 6'd0);
    pend_play = (q_sum > 6'(PEND_MAX)) ? 4'(PEND_MAX) : q_sum[3:0];

    inc_tens = tens;
    inc_ones = ones;
    if (ones == 4'd9) begin
      if (tens != 4'd9) begin
        inc_ones = 4'd0;
        inc_tens = tens + 4'd1;
      end
    end else begin
      inc_ones = ones + 4'd1;
    end

    to_blink = !game_start &&
               (((state == PLAY) && game_over && !dec && !award) ||
                ((state == DRAIN) && !dec));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      tens       <= 4'd0;
      ones       <= 4'd0;
      pending    <= 4'd0;
      busy       <= 1'b0;
      display_en <= 1'b1;
      tick_cnt   <= '0;
      toggle_cnt <= '0;
    end else if (game_start) begin
      state      <= PLAY;
      tens       <= 4'd0;
      ones       <= 4'd0;
      pending    <= 4'd0;
      busy       <= 1'b0;
      display_en <= 1'b1;
      tick_cnt   <= '0;
      toggle_cnt <= '0;
    end else begin
      case (state)
        IDLE: ;
        PLAY: begin
          if (dec) begin
            tens <= inc_tens;
            ones <= inc_ones;
          end
          pending <= pend_play;
          busy    <= (pend_play != 4'd0);
          if (game_over) begin
            if (to_blink) begin
              state      <= BLINK;
              display_en <= 1'b0;
              tick_cnt   <= '0;
              toggle_cnt <= '0;
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (to_blink) begin
            state      <= BLINK;
            display_en <= 1'b0;
            tick_cnt   <= '0;
            toggle_cnt <= '0;
          end else begin
            tens    <= inc_tens;
            ones    <= inc_ones;
            pending <= pending - 4'd1;
            busy    <= (pending != 4'd1);
          end
        end
        BLINK: begin
          if (frame_tick) begin
            if (tick_cnt == TICK_W'(BLINK_HALF - 1)) begin
              tick_cnt <= '0;
              // The last toggle ends a visible half, so the display stays on.
              if (toggle_cnt == TOG_W'(2 * BLINK_CYCLES - 1)) begin
                toggle_cnt <= '0;
                display_en <= 1'b1;
                state      <= DONE;
              end else begin
                toggle_cnt <= toggle_cnt + 1'b1;
                display_en <= ~display_en;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        DONE: ;
        default: state <= IDLE;
      endcase
    end
  end

  assign phase = state;

`ifdef HISCORE_EN
  // Scores are 2-digit BCD, so an unsigned 8-bit compare orders them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hi_tens  <= 4'd0;
      hi_ones  <= 4'd0;
      new_high <= 1'b0;
    end else if (game_start) begin
      new_high <= 1'b0;
    end else if (to_blink && ({tens, ones} > {hi_tens, hi_ones})) begin
      hi_tens  <= tens;
      hi_ones  <= ones;
      new_high <= 1'b1;
    end
  end
`else
  assign hi_tens  = 4'd0;
  assign hi_ones  = 4'd0;
  assign new_high = 1'b0;
`endif

endmodule

// File: tb/tb_score_seq.sv
// tb_score_seq - self-checking bench for score_seq.
// A behavioural model (integer score, integer queue depth, frame count within
// the blink sequence) predicts every output each cycle; a single compare
// process checks the DUT against it, and directed scenarios pin literal values.
module tb_score_seq;

  localparam int BP    = 5;
  localparam int PMAX  = 15;
  localparam int HALF  = 16;
  localparam int CYC   = 4;
`ifdef HISCORE_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif
  localparam int W = 22;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic game_start = 1'b0, game_over = 1'b0, eat = 1'b0, bonus = 1'b0, frame_tick = 1'b0;
  logic [3:0] tens, ones, hi_tens, hi_ones;
  logic busy, display_en, new_high;
  logic [2:0] phase;

  initial forever #5 clk = ~clk;

  score_seq #(.BONUS_PTS(BP), .PEND_MAX(PMAX), .BLINK_HALF(HALF), .BLINK_CYCLES(CYC)) dut (
    .clk(clk), .rst(rst), .game_start(game_start), .game_over(game_over),
    .eat(eat), .bonus(bonus), .frame_tick(frame_tick),
    .tens(tens), .ones(ones), .hi_tens(hi_tens), .hi_ones(hi_ones),
    .busy(busy), .display_en(display_en), .new_high(new_high), .phase(phase)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // States: 0 idle, 1 play, 2 drain, 3 blink, 4 done.
  int m_state = 0, m_score = 0, m_pend = 0, m_hi = 0, m_ticks = 0;
  bit m_nh = 0;

  function automatic void finish_game();
    if (HI_EN && m_score > m_hi) begin
      m_hi = m_score;
      m_nh = 1;
    end
    m_state = 3;
    m_ticks = 0;
  endfunction

  always @(posedge clk) begin
    int aw, old, nxt;
    bit disp;
    aw  = int'(eat) + (bonus ? BP : 0);
    old = m_pend;
    if (!rst) begin
      m_state = 0; m_score = 0; m_pend = 0; m_hi = 0; m_nh = 0; m_ticks = 0;
    end else if (game_start) begin
      m_state = 1; m_score = 0; m_pend = 0; m_nh = 0; m_ticks = 0;
    end else begin
      case (m_state)
        1: begin
          if (old > 0 && m_score < 99) m_score++;
          nxt = old - ((old > 0) ? 1 : 0) + aw;
          m_pend = (nxt > PMAX) ? PMAX : nxt;
          if (game_over) begin
            if (old > 0 || aw > 0) m_state = 2;
            else finish_game();
          end
        end
        2: begin
          if (m_pend == 0) finish_game();
          else begin
            if (m_score < 99) m_score++;
            m_pend--;
          end
        end
        3: begin
          if (frame_tick) begin
            m_ticks++;
            if (m_ticks == 2 * CYC * HALF) m_state = 4;
          end
        end
        default: ;
      endcase
    end
    // Blink starts dark and alternates every HALF ticks.
    disp = (m_state == 3) ? (((m_ticks / HALF) % 2) == 1) : 1'b1;
    exp_q.push_back({4'(m_score / 10), 4'(m_score % 10),
                     4'(m_hi / 10), 4'(m_hi % 10),
                     m_pend != 0, disp, m_nh, 3'(m_state)});
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("tens",       tens,       e[21:18]);
      chk("ones",       ones,       e[17:14]);
      chk("hi_tens",    hi_tens,    e[13:10]);
      chk("hi_ones",    hi_ones,    e[9:6]);
      chk("busy",       busy,       e[5]);
      chk("display_en", display_en, e[4]);
      chk("new_high",   new_high,   e[3]);
      chk("phase",      phase,      e[2:0]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic gs, input logic go,
                       input logic e, input logic b, input logic ft);
    rst = r; game_start = gs; game_over = go; eat = e; bonus = b; frame_tick = ft;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0);
  endtask

  task automatic eats(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 1, 0, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("rst_phase", phase, 0);
    chk("rst_score", {tens, ones}, 0);
    chk("rst_disp", display_en, 1);
    chk("rst_busy", busy, 0);

    // Three consecutive eats
    drive(1, 1, 0, 0, 0, 0);
    eats(3);
    chk("eat3_busy_hold", busy, 1);
    idle(1);
    chk("eat3_busy_off", busy, 0);
    chk("eat3_ones", ones, 3);
    chk("eat3_tens", tens, 0);
    chk("eat3_phase", phase, 1);

    // Score 08, eat+bonus together -> 6 queued
    eats(5);
    idle(2);
    chk("s08", {tens, ones}, 8'h08);
    drive(1, 0, 0, 1, 1, 0);
    chk("eb_busy", busy, 1);
    idle(5);
    chk("eb_busy5", busy, 1);
    idle(1);
    chk("eb_busy6", busy, 0);
    chk("eb_score", {tens, ones}, 8'h14);

    // Saturation at 99
    eats(83);
    idle(1);
    chk("s97", {tens, ones}, 8'h97);
    drive(1, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 1, 0);
    idle(10);
    chk("sat_score", {tens, ones}, 8'h99);
    chk("sat_busy", busy, 0);

    // Game ending at 16 through DRAIN, then blink
    drive(1, 1, 0, 0, 0, 0);
    eats(11);
    idle(2);
    drive(1, 0, 0, 0, 1, 0);
    idle(1);
    chk("pre_over_score", {tens, ones}, 8'h12);
    drive(1, 0, 1, 0, 0, 0);
    chk("drain_phase", phase, 2);
    idle(3);
    chk("drain_phase3", phase, 2);
    chk("drain_score", {tens, ones}, 8'h16);
    idle(1);
    chk("blink_phase", phase, 3);
    chk("blink_disp0", display_en, 0);
    chk("hi16", {hi_tens, hi_ones}, HI_EN ? 8'h16 : 8'h00);
    chk("nh1", new_high, HI_EN ? 1 : 0);
    ticks(15);
    chk("blink_low15", display_en, 0);
    ticks(1);
    chk("blink_high16", display_en, 1);
    ticks(111);
    chk("blink_last", phase, 3);
    ticks(1);
    chk("done_phase", phase, 4);
    chk("done_disp", display_en, 1);

    // Second game ties the high score, third beats it
    drive(1, 1, 0, 0, 0, 0);
    eats(16);
    idle(2);
    drive(1, 0, 1, 0, 0, 0);
    chk("g2_phase", phase, 3);
    chk("g2_nh", new_high, 0);
    chk("g2_hi", {hi_tens, hi_ones}, HI_EN ? 8'h16 : 8'h00);
    drive(1, 1, 0, 0, 0, 0);
    eats(20);
    idle(2);
    drive(1, 0, 1, 0, 0, 0);
    chk("g3_hi", {hi_tens, hi_ones}, HI_EN ? 8'h20 : 8'h00);
    chk("g3_nh", new_high, HI_EN ? 1 : 0);

    // game_start mid-blink, then reset mid-play
    ticks(5);
    drive(1, 1, 0, 0, 0, 0);
    chk("mid_phase", phase, 1);
    chk("mid_disp", display_en, 1);
    chk("mid_score", {tens, ones}, 0);
    chk("mid_hi", {hi_tens, hi_ones}, HI_EN ? 8'h20 : 8'h00);
    eats(3);
    drive(0, 0, 0, 1, 0, 0);
    chk("rst2_phase", phase, 0);
    chk("rst2_hi", {hi_tens, hi_ones}, 0);
    chk("rst2_busy", busy, 0);
    chk("rst2_score", {tens, ones}, 0);

    // Randomized traffic
    for (int i = 0; i < 20000; i++) begin
      drive(($urandom_range(0, 2999) == 0) ? 1'b0 : 1'b1,
            $urandom_range(0, 399) == 0,
            $urandom_range(0, 79) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 1) == 0);
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
